// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan controller.
// SEG_HEX holds gfedcba patterns with a '1' meaning the segment is lit.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int PWM_STEPS  = 16;
  localparam int SEG_DP     = 7;

  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to gfedcba segment pattern (active-high).
import seg7_pkg::*;

module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with per-slot PWM
// brightness, step-0 dead time and frame-boundary (tear-free) updates.
import seg7_pkg::*;

module seg7_scan_ctrl #(
  parameter int STEP_CYCLES     = 1000,
  parameter bit SEG_ACTIVE_LOW  = 1'b1,
  parameter bit DIG_ACTIVE_HIGH = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_blank,
  input  logic [3:0]  brightness,
  output logic [7:0]  seg,
  output logic [3:0]  dig,
  output logic        frame_tick
);

  localparam int              CYC_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(STEP_CYCLES - 1);
  localparam logic [3:0]      STEP_LAST = 4'(PWM_STEPS - 1);
  localparam logic [7:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]      DIG_OFF   = DIG_ACTIVE_HIGH ? 4'h0 : 4'hF;

  logic [CYC_W-1:0] cyc;
  logic [3:0]       step;
  logic [1:0]       digit;
  logic             cyc_last;
  logic             step_last;
  logic             frame_end;

  logic             pending;
  logic [15:0]      pend_data;
  logic [3:0]       pend_dp;
  logic [3:0]       pend_blank;
  logic [15:0]      act_data;
  logic [3:0]       act_dp;
  logic [3:0]       act_blank;
  logic [3:0]       bright_q;
  logic             xfer;

  logic [3:0]       cur_nibble;
  logic [6:0]       cur_hex;
  logic [7:0]       seg_on;
  logic [3:0]       dig_onehot;
  logic             dig_en;
  logic [7:0]       seg_nxt;
  logic [3:0]       dig_nxt;

  assign cyc_last  = (cyc == CYC_LAST);
  assign step_last = (step == STEP_LAST);
  assign frame_end = cyc_last && step_last && (digit == 2'(NUM_DIGITS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cyc   <= '0;
      step  <= '0;
      digit <= '0;
    end else if (cyc_last) begin
      cyc  <= '0;
      step <= step + 4'd1;
      if (step_last) begin
        digit <= digit + 2'd1;
      end
    end else begin
      cyc <= cyc + CYC_W'(1);
    end
  end

  // An accept can only happen with nothing pending, so it never collides
  // with a commit; an accept on the frame-end cycle waits for the next frame.
  assign xfer     = wr_valid && !pending;
  assign wr_ready = !pending;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending    <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= 4'hF;
    end else if (xfer) begin
      pending    <= 1'b1;
      pend_data  <= wr_data;
      pend_dp    <= wr_dp;
      pend_blank <= wr_blank;
    end else if (frame_end && pending) begin
      pending   <= 1'b0;
      act_data  <= pend_data;
      act_dp    <= pend_dp;
      act_blank <= pend_blank;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bright_q <= '0;
    end else if (step == 4'd0 && cyc == '0) begin
      bright_q <= brightness;
    end
  end

  assign cur_nibble = act_data[{digit, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nibble (cur_nibble),
    .segs   (cur_hex)
  );

  // Step 0 is the ghosting dead time: step >= 1 excludes it for any brightness.
  always_comb begin
    seg_on     = {act_dp[digit], cur_hex};
    dig_onehot = 4'b0001 << digit;
    dig_en     = (step != 4'd0) && (step <= bright_q) && !act_blank[digit];
    seg_nxt    = SEG_OFF;
    dig_nxt    = DIG_OFF;
    if (dig_en) begin
      seg_nxt = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
      dig_nxt = DIG_ACTIVE_HIGH ? dig_onehot : ~dig_onehot;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg        <= SEG_OFF;
      dig        <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_nxt;
      dig        <= dig_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (STEP_CYCLES=2, 128-cycle frames):
// per-frame expectations are queued by the stimulus and checked at each frame_tick.
module tb_seg7_scan_ctrl;

  logic        CLK;
  logic        RST;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_blank;
  logic [3:0]  brightness;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_tick;

  seg7_scan_ctrl #(.STEP_CYCLES(2)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_blank   (wr_blank),
    .brightness (brightness),
    .seg        (seg),
    .dig        (dig),
    .frame_tick (frame_tick)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0][7:0] seg;
    logic [3:0][5:0] on;
  } frame_exp_t;

  typedef struct {
    logic [3:0]      bright;
    bit              wr;
    bit              hold;
    bit              late;
    logic [15:0]     data;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][7:0] exp_seg;
    logic [3:0][5:0] exp_on;
  } row_t;

  frame_exp_t exp_q[$];
  row_t       rows[10];
  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: accumulates per-digit on-time and segment value, compares at frame_tick.
  initial begin
    int         on_cnt[4];
    logic [7:0] seg_last[4];
    bit         incons[4];
    frame_exp_t e;
    for (int d = 0; d < 4; d++) begin
      on_cnt[d] = 0; seg_last[d] = 8'hFF; incons[d] = 1'b0;
    end
    forever begin
      @(negedge CLK);
      if (!mon_en) begin
        for (int d = 0; d < 4; d++) begin
          on_cnt[d] = 0; seg_last[d] = 8'hFF; incons[d] = 1'b0;
        end
        continue;
      end
      check("dig_onehot", 32'($countones(dig) <= 1), 1);
      if (dig == 4'b0000) check("seg_idle", seg, 8'hFF);
      for (int d = 0; d < 4; d++) begin
        if (dig[d]) begin
          if (on_cnt[d] > 0 && seg !== seg_last[d]) incons[d] = 1'b1;
          on_cnt[d]++;
          seg_last[d] = seg;
        end
      end
      if (frame_tick) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL frame_unexpected: got frame_tick expected no frame (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          for (int d = 0; d < 4; d++) begin
            check($sformatf("on_cycles_d%0d", d), on_cnt[d], 32'(e.on[d]));
            check($sformatf("seg_d%0d", d), seg_last[d], e.seg[d]);
            check($sformatf("seg_stable_d%0d", d), incons[d], 0);
          end
        end
        for (int d = 0; d < 4; d++) begin
          on_cnt[d] = 0; seg_last[d] = 8'hFF; incons[d] = 1'b0;
        end
      end
    end
  end

  task automatic do_write(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    check("ready_before_wr", wr_ready, 1);
    wr_valid = 1'b1; wr_data = d; wr_dp = p; wr_blank = b;
    @(posedge CLK);
    @(negedge CLK);
    wr_valid = 1'b0;
    check("ready_after_wr", wr_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t r;
    time  t0;
    int   ready_hi;
    bit   got_tick;

    rows[0] = '{bright:4'd15, wr:1, hold:0, late:0, data:16'h1234, dp:4'h0, blank:4'h0,
                exp_seg:{4{8'hFF}}, exp_on:{4{6'd0}}};
    rows[1] = '{bright:4'd15, wr:1, hold:1, late:0, data:16'hAAAA, dp:4'h0, blank:4'h0,
                exp_seg:{8'hF9, 8'hA4, 8'hB0, 8'h99}, exp_on:{4{6'd30}}};
    rows[2] = '{bright:4'd15, wr:1, hold:0, late:0, data:16'h5555, dp:4'h0, blank:4'h0,
                exp_seg:{4{8'h88}}, exp_on:{4{6'd30}}};
    rows[3] = '{bright:4'd15, wr:0, hold:0, late:0, data:16'h0000, dp:4'h0, blank:4'h0,
                exp_seg:{4{8'h92}}, exp_on:{4{6'd30}}};
    rows[4] = '{bright:4'd0, wr:0, hold:0, late:0, data:16'h0000, dp:4'h0, blank:4'h0,
                exp_seg:{4{8'hFF}}, exp_on:{4{6'd0}}};
    rows[5] = '{bright:4'd1, wr:1, hold:0, late:0, data:16'hF00E, dp:4'b0001, blank:4'b0100,
                exp_seg:{4{8'h92}}, exp_on:{4{6'd2}}};
    rows[6] = '{bright:4'd15, wr:0, hold:0, late:0, data:16'h0000, dp:4'h0, blank:4'h0,
                exp_seg:{8'h8E, 8'hFF, 8'hC0, 8'h06}, exp_on:{6'd30, 6'd0, 6'd30, 6'd30}};
    rows[7] = '{bright:4'd15, wr:0, hold:0, late:1, data:16'hB8D6, dp:4'h0, blank:4'h0,
                exp_seg:{8'h8E, 8'hFF, 8'hC0, 8'h06}, exp_on:{6'd30, 6'd0, 6'd30, 6'd30}};
    rows[8] = '{bright:4'd15, wr:0, hold:0, late:0, data:16'h0000, dp:4'h0, blank:4'h0,
                exp_seg:{8'h8E, 8'hFF, 8'hC0, 8'h06}, exp_on:{6'd30, 6'd0, 6'd30, 6'd30}};
    rows[9] = '{bright:4'd7, wr:0, hold:0, late:0, data:16'h0000, dp:4'h0, blank:4'h0,
                exp_seg:{8'h83, 8'h80, 8'hA1, 8'h82}, exp_on:{4{6'd14}}};

    RST = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_dp = '0; wr_blank = '0; brightness = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    brightness = 4'd15;
    do_write(16'h1234, 4'h0, 4'h0);
    for (int k = 0; k < 400 && dig == 4'b0000; k++) @(negedge CLK);
    check("pre_reset_lit", 32'(dig != 4'b0000), 1);

    // Mid-run reset must clear outputs immediately, without a clock edge.
    RST = 1'b1;
    #1;
    check("rst_seg", seg, 8'hFF);
    check("rst_dig", dig, 4'b0000);
    check("rst_ready", wr_ready, 1);
    check("rst_tick", frame_tick, 0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    mon_en = 1'b1;

    for (int j = 0; j < 10; j++) begin
      r = rows[j];
      t0 = $time;
      brightness = r.bright;
      exp_q.push_back('{seg:r.exp_seg, on:r.exp_on});
      if (r.wr) do_write(r.data, r.dp, r.blank);
      if (r.hold) begin
        wr_valid = 1'b1; wr_data = rows[j+1].data; wr_dp = rows[j+1].dp; wr_blank = rows[j+1].blank;
      end
      ready_hi = 0;
      got_tick = 1'b0;
      if (r.late) begin
        check("ready_before_late", wr_ready, 1);
        repeat (127) @(negedge CLK);
        wr_valid = 1'b1; wr_data = r.data; wr_dp = r.dp; wr_blank = r.blank;
        @(posedge CLK);
        @(negedge CLK);
        wr_valid = 1'b0;
        check("late_tick", frame_tick, 1);
        got_tick = frame_tick;
      end else begin
        for (int k = 0; k < 300; k++) begin
          @(negedge CLK);
          if (frame_tick) begin
            got_tick = 1'b1;
            break;
          end
          if (wr_ready) ready_hi++;
        end
        if (!got_tick) begin
          n_vec++; n_err++;
          $display("FAIL tick_timeout row %0d: got no frame_tick expected one within 300 cycles", j);
        end
      end
      if (r.hold) check("hold_ready_high_cycles", ready_hi, 0);
      check($sformatf("frame_period_row%0d", j), 32'(($time - t0) / 10), 128);
      check($sformatf("ready_at_tick_row%0d", j), wr_ready, 32'(!r.late));
    end

    @(negedge CLK);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
